// File: rtl/cpu_step_controller.sv
// Single-step / free-run clock-enable controller for the CPU datapath, with an optional PC breakpoint.
// Define STEP_COUNTER_EN to build the 16-bit step_count counter; otherwise step_count is tied to zero.
module cpu_step_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RUN_DIV         = 25000000,
  parameter int PC_W            = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            step_btn_n,
  input  logic            run_sw,
  input  logic            brk_en,
  input  logic [PC_W-1:0] brk_addr,
  input  logic [PC_W-1:0] pc,
  output logic            cpu_en,
  output logic            halted,
  output logic [1:0]      state,
  output logic [15:0]     step_count
);

  typedef enum logic [1:0] {
    ST_STEP = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DV_W-1:0] DV_LAST = DV_W'(RUN_DIV - 1);

  logic [1:0]      btn_sync;
  logic [1:0]      run_sync;
  logic            btn_s;
  logic            run_s;
  logic [DB_W-1:0] db_cnt;
  logic            db_level;
  logic            press;
  state_t          state_q;
  state_t          state_d;
  logic [DV_W-1:0] div_q;
  logic [DV_W-1:0] div_d;
  logic            en_d;
  logic            brk_hit;

  // Synchronisers reset to the idle levels: button released, run switch off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_sync <= 2'b11;
      run_sync <= 2'b00;
    end else begin
      btn_sync <= {btn_sync[0], step_btn_n};
      run_sync <= {run_sync[0], run_sw};
    end
  end

  assign btn_s = btn_sync[1];
  assign run_s = run_sync[1];

  // The level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt   <= '0;
      db_level <= 1'b1;
      press    <= 1'b0;
    end else begin
      press <= 1'b0;
      if (btn_s == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt   <= '0;
        db_level <= btn_s;
        press    <= ~btn_s;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  assign brk_hit = brk_en & (pc == brk_addr);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    en_d    = 1'b0;
    case (state_q)
      ST_STEP: begin
        en_d = press;
        if (run_s) begin
          state_d = ST_RUN;
          div_d   = '0;
        end
      end
      ST_RUN: begin
        if (!run_s) begin
          state_d = ST_STEP;
          div_d   = '0;
        end else if (div_q == DV_LAST) begin
          div_d = '0;
          // Halting here leaves the breakpoint instruction unexecuted.
          if (brk_hit) state_d = ST_HALT;
          else         en_d    = 1'b1;
        end else begin
          div_d = div_q + DV_W'(1);
        end
      end
      ST_HALT: begin
        en_d = press;
        if (!run_s) state_d = ST_STEP;
      end
      default: state_d = ST_STEP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_STEP;
      div_q   <= '0;
      cpu_en  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cpu_en  <= en_d;
    end
  end

  assign state  = state_q;
  assign halted = (state_q == ST_HALT);

`ifdef STEP_COUNTER_EN
  logic [15:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count_q <= 16'h0000;
    else if (en_d) count_q <= count_q + 16'd1;
  end

  assign step_count = count_q;
`else
  assign step_count = 16'h0000;
`endif

endmodule

// File: tb/tb_cpu_step_controller.sv
// Directed bench for cpu_step_controller with a small PC model that advances on cpu_en.
// step_count expectations follow STEP_COUNTER_EN when it is defined for the build.
module tb_cpu_step_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        step_btn_n = 1'b1;
  logic        run_sw = 1'b0;
  logic        brk_en = 1'b0;
  logic [7:0]  brk_addr = 8'h00;
  logic [7:0]  pc_r = 8'h00;
  logic        pc_clear = 1'b0;
  logic        cpu_en;
  logic        halted;
  logic [1:0]  state;
  logic [15:0] step_count;

  int n_assert = 0;
  int n_fail = 0;
  int en_count = 0;
  int consec = 0;
  int base;
  logic prev_en = 1'b0;

  cpu_step_controller #(.DEBOUNCE_CYCLES(4), .RUN_DIV(5), .PC_W(8)) dut (
    .clk(clk), .rst(rst), .step_btn_n(step_btn_n), .run_sw(run_sw),
    .brk_en(brk_en), .brk_addr(brk_addr), .pc(pc_r),
    .cpu_en(cpu_en), .halted(halted), .state(state), .step_count(step_count)
  );

  always #5 clk = ~clk;

  // Stand-in for the CPU PC register: advances on edges where cpu_en is high.
  always @(posedge clk) begin
    if (rst || pc_clear) pc_r <= 8'h00;
    else if (cpu_en === 1'b1) pc_r <= pc_r + 8'h01;
  end

  always @(negedge clk) begin
    if (cpu_en === 1'b1) en_count = en_count + 1;
    if (cpu_en === 1'b1 && prev_en) consec = consec + 1;
    prev_en = (cpu_en === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check_count(input string tag);
`ifdef STEP_COUNTER_EN
    check(tag, {16'h0, step_count}, {16'h0, 16'(en_count)});
`else
    check(tag, {16'h0, step_count}, 32'h0);
`endif
  endtask

  initial begin
    // Asynchronous reset before the first clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_cpu_en", {31'h0, cpu_en}, 32'h0);
    check("rst_state", {30'h0, state}, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
    check("rst_step_count", {16'h0, step_count}, 32'h0);
    cycles(3);
    rst = 1'b0;
    cycles(3);

    // Short glitch must not produce a press.
    base = en_count;
    step_btn_n = 1'b0;
    cycles(2);
    step_btn_n = 1'b1;
    cycles(12);
    check("glitch_no_pulse", 32'(en_count - base), 32'h0);

    // A long press gives exactly one pulse; release gives none.
    step_btn_n = 1'b0;
    cycles(10);
    step_btn_n = 1'b1;
    cycles(15);
    check("press_one_pulse", 32'(en_count - base), 32'h1);
    check("press_state", {30'h0, state}, 32'h0);
    check("press_pc", {24'h0, pc_r}, 32'h1);
    check_count("press_step_count");

    // Free run without breakpoint: pulses every 5 cycles.
    base = en_count;
    run_sw = 1'b1;
    cycles(28);
    check("run_pulses", 32'(en_count - base), 32'h5);
    check("run_state", {30'h0, state}, 32'h1);
    check("run_halted", {31'h0, halted}, 32'h0);
    check_count("run_step_count");

    // Back to STEP, then run toward a breakpoint at pc=3 from pc=0.
    run_sw = 1'b0;
    cycles(5);
    check("run_to_step_state", {30'h0, state}, 32'h0);
    pc_clear = 1'b1;
    cycles(1);
    pc_clear = 1'b0;
    brk_en = 1'b1;
    brk_addr = 8'h03;
    base = en_count;
    run_sw = 1'b1;
    cycles(30);
    check("brk_pulses", 32'(en_count - base), 32'h3);
    check("brk_state", {30'h0, state}, 32'h2);
    check("brk_halted", {31'h0, halted}, 32'h1);
    check("brk_pc", {24'h0, pc_r}, 32'h3);

    // A press while halted steps past the breakpoint.
    step_btn_n = 1'b0;
    cycles(10);
    step_btn_n = 1'b1;
    cycles(15);
    check("halt_step_pulses", 32'(en_count - base), 32'h4);
    check("halt_step_pc", {24'h0, pc_r}, 32'h4);
    check("halt_step_state", {30'h0, state}, 32'h2);
    check_count("halt_step_count");

    // Leaving HALT takes the two synchroniser stages plus the state register.
    base = en_count;
    run_sw = 1'b0;
    cycles(2);
    check("halt_exit_latency", {30'h0, state}, 32'h2);
    cycles(1);
    check("halt_exit_state", {30'h0, state}, 32'h0);
    check("halt_exit_halted", {31'h0, halted}, 32'h0);
    cycles(10);
    check("halt_exit_no_pulse", 32'(en_count - base), 32'h0);

    // Reset in the middle of free run.
    brk_en = 1'b0;
    run_sw = 1'b1;
    cycles(10);
    check("pre_rst_state", {30'h0, state}, 32'h1);
    rst = 1'b1;
    #1;
    check("mid_rst_state", {30'h0, state}, 32'h0);
    check("mid_rst_cpu_en", {31'h0, cpu_en}, 32'h0);
    check("mid_rst_step_count", {16'h0, step_count}, 32'h0);
    run_sw = 1'b0;
    cycles(2);
    rst = 1'b0;
    cycles(3);

    check("no_consecutive_en", 32'(consec), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
